// File: rtl/tap_controller.sv
// IEEE 1149.1 TAP controller with instruction register and DR select decode.
// FSM and IR shift advance on rising TCK; DR control strobes and TDO change on falling TCK.
module tap_controller #(
    parameter int unsigned          IR_WIDTH  = 4,
    parameter logic [IR_WIDTH-1:0]  OP_EXTEST = IR_WIDTH'(0),
    parameter logic [IR_WIDTH-1:0]  OP_IDCODE = IR_WIDTH'(1),
    parameter logic [IR_WIDTH-1:0]  OP_SAMPLE = IR_WIDTH'(2),
    parameter logic [IR_WIDTH-1:0]  OP_BYPASS = {IR_WIDTH{1'b1}}
) (
    input  logic                TCK,
    input  logic                Reset,
    input  logic                TMS,
    input  logic                TDI,
    input  logic                BypassTDO,
    input  logic                IdcodeTDO,
    input  logic                BsrTDO,
    output logic                TDO,
    output logic                TDOEnable,
    output logic                ShiftDR,
    output logic                ClockDR,
    output logic                UpdateDR,
    output logic                SelectBypass,
    output logic                SelectIdcode,
    output logic                SelectBsr,
    output logic                Mode,
    output logic [IR_WIDTH-1:0] Instruction,
    output logic [3:0]          TapState
);

    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(1);

    typedef enum logic [3:0] {
        S_EX2_DR = 4'h0,
        S_EX1_DR = 4'h1,
        S_SH_DR  = 4'h2,
        S_PAU_DR = 4'h3,
        S_SEL_IR = 4'h4,
        S_UPD_DR = 4'h5,
        S_CAP_DR = 4'h6,
        S_SEL_DR = 4'h7,
        S_EX2_IR = 4'h8,
        S_EX1_IR = 4'h9,
        S_SH_IR  = 4'hA,
        S_PAU_IR = 4'hB,
        S_RTI    = 4'hC,
        S_UPD_IR = 4'hD,
        S_CAP_IR = 4'hE,
        S_TLR    = 4'hF
    } tap_state_e;

    tap_state_e          r_state;
    tap_state_e          w_next_state;
    logic [IR_WIDTH-1:0] r_ir_shift;
    logic [IR_WIDTH-1:0] r_instr;
    logic                r_shift_dr;
    logic                r_update_dr;
    logic                r_clk_en;
    logic                r_tdo;
    logic                r_tdo_en;
    logic                w_is_extest;
    logic                w_is_idcode;
    logic                w_is_sample;
    logic                w_dr_tdo;

    always_ff @(posedge TCK or posedge Reset) begin
        if (Reset) begin
            r_state <= S_TLR;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_TLR:    w_next_state = TMS ? S_TLR    : S_RTI;
            S_RTI:    w_next_state = TMS ? S_SEL_DR : S_RTI;
            S_SEL_DR: w_next_state = TMS ? S_SEL_IR : S_CAP_DR;
            S_CAP_DR: w_next_state = TMS ? S_EX1_DR : S_SH_DR;
            S_SH_DR:  w_next_state = TMS ? S_EX1_DR : S_SH_DR;
            S_EX1_DR: w_next_state = TMS ? S_UPD_DR : S_PAU_DR;
            S_PAU_DR: w_next_state = TMS ? S_EX2_DR : S_PAU_DR;
            S_EX2_DR: w_next_state = TMS ? S_UPD_DR : S_SH_DR;
            S_UPD_DR: w_next_state = TMS ? S_SEL_DR : S_RTI;
            S_SEL_IR: w_next_state = TMS ? S_TLR    : S_CAP_IR;
            S_CAP_IR: w_next_state = TMS ? S_EX1_IR : S_SH_IR;
            S_SH_IR:  w_next_state = TMS ? S_EX1_IR : S_SH_IR;
            S_EX1_IR: w_next_state = TMS ? S_UPD_IR : S_PAU_IR;
            S_PAU_IR: w_next_state = TMS ? S_EX2_IR : S_PAU_IR;
            S_EX2_IR: w_next_state = TMS ? S_UPD_IR : S_SH_IR;
            S_UPD_IR: w_next_state = TMS ? S_SEL_DR : S_RTI;
            default:  w_next_state = S_TLR;
        endcase
    end

    // IR shift path: capture fixed pattern, shift toward bit 0
    always_ff @(posedge TCK or posedge Reset) begin
        if (Reset) begin
            r_ir_shift <= IR_CAPTURE;
        end else if (r_state == S_CAP_IR) begin
            r_ir_shift <= IR_CAPTURE;
        end else if (r_state == S_SH_IR) begin
            r_ir_shift <= {TDI, r_ir_shift[IR_WIDTH-1:1]};
        end
    end

    // Falling-edge controls keep DR strobes and TDO stable around rising TCK
    always_ff @(negedge TCK or posedge Reset) begin
        if (Reset) begin
            r_instr     <= OP_IDCODE;
            r_shift_dr  <= 1'b0;
            r_update_dr <= 1'b0;
            r_clk_en    <= 1'b0;
            r_tdo       <= 1'b0;
            r_tdo_en    <= 1'b0;
        end else begin
            r_shift_dr  <= (r_state == S_SH_DR);
            r_update_dr <= (r_state == S_UPD_DR);
            r_clk_en    <= (r_state == S_CAP_DR) || (r_state == S_SH_DR);
            if (r_state == S_UPD_IR) begin
                r_instr <= r_ir_shift;
            end else if (r_state == S_TLR) begin
                r_instr <= OP_IDCODE;
            end
            if (r_state == S_SH_IR) begin
                r_tdo    <= r_ir_shift[0];
                r_tdo_en <= 1'b1;
            end else if (r_state == S_SH_DR) begin
                r_tdo    <= w_dr_tdo;
                r_tdo_en <= 1'b1;
            end else begin
                r_tdo    <= 1'b0;
                r_tdo_en <= 1'b0;
            end
        end
    end

    assign w_is_extest = (r_instr == OP_EXTEST);
    assign w_is_idcode = (r_instr == OP_IDCODE);
    assign w_is_sample = (r_instr == OP_SAMPLE);

    assign SelectBsr    = w_is_extest | w_is_sample;
    assign SelectIdcode = w_is_idcode;
    assign SelectBypass = (r_instr == OP_BYPASS) | ~(w_is_extest | w_is_idcode | w_is_sample);
    assign Mode         = w_is_extest;

    assign w_dr_tdo = SelectBsr ? BsrTDO : (SelectIdcode ? IdcodeTDO : BypassTDO);

    // Enable only changes while TCK is low, so the gated clock cannot glitch
    assign ClockDR     = TCK & r_clk_en;
    assign ShiftDR     = r_shift_dr;
    assign UpdateDR    = r_update_dr;
    assign TDO         = r_tdo;
    assign TDOEnable   = r_tdo_en;
    assign Instruction = r_instr;
    assign TapState    = r_state;

endmodule

// File: tb/tb_tap_controller.sv
// Bench for tap_controller: directed scans plus random TMS/TDI walk against a table-driven model.
// External bypass/idcode/boundary-scan DRs are modelled here and clocked by the DUT's ClockDR.
module tb_tap_controller;

    logic       TCK = 1'b0;
    logic       Reset;
    logic       TMS;
    logic       TDI;
    logic       BypassTDO;
    logic       IdcodeTDO;
    logic       BsrTDO;
    logic       TDO;
    logic       TDOEnable;
    logic       ShiftDR;
    logic       ClockDR;
    logic       UpdateDR;
    logic       SelectBypass;
    logic       SelectIdcode;
    logic       SelectBsr;
    logic       Mode;
    logic [3:0] Instruction;
    logic [3:0] TapState;

    tap_controller dut (
        .TCK(TCK), .Reset(Reset), .TMS(TMS), .TDI(TDI),
        .BypassTDO(BypassTDO), .IdcodeTDO(IdcodeTDO), .BsrTDO(BsrTDO),
        .TDO(TDO), .TDOEnable(TDOEnable), .ShiftDR(ShiftDR), .ClockDR(ClockDR),
        .UpdateDR(UpdateDR), .SelectBypass(SelectBypass), .SelectIdcode(SelectIdcode),
        .SelectBsr(SelectBsr), .Mode(Mode), .Instruction(Instruction), .TapState(TapState)
    );

    always #5 TCK = ~TCK;

    // External data registers seen by the DUT
    logic       r_byp;
    logic [7:0] r_idc;
    logic [7:0] r_bsr;
    int         clk_edges = 0;
    int         upd_pulses = 0;

    assign BypassTDO = r_byp;
    assign IdcodeTDO = r_idc[0];
    assign BsrTDO    = r_bsr[0];

    always @(posedge ClockDR) begin
        clk_edges <= clk_edges + 1;
        r_byp     <= ShiftDR ? TDI : 1'b0;
        r_idc     <= ShiftDR ? {TDI, r_idc[7:1]} : 8'h3C;
        r_bsr     <= ShiftDR ? {TDI, r_bsr[7:1]} : 8'hA5;
    end

    always @(posedge UpdateDR) upd_pulses <= upd_pulses + 1;

    // Reference model state
    logic [3:0] nx0 [16] = '{4'h2, 4'h3, 4'h2, 4'h3, 4'hE, 4'hC, 4'h2, 4'h6,
                             4'hA, 4'hB, 4'hA, 4'hB, 4'hC, 4'hC, 4'hA, 4'hC};
    logic [3:0] nx1 [16] = '{4'h5, 4'h5, 4'h1, 4'h0, 4'hF, 4'h7, 4'h1, 4'h4,
                             4'hD, 4'hD, 4'h9, 4'h8, 4'h7, 4'h7, 4'h9, 4'hF};
    logic [3:0] m_state, m_ir, m_instr;
    logic       m_shdr, m_upd, m_en, m_tdo, m_tdoen;
    logic       m_byp;
    logic [7:0] m_idc, m_bsr;
    int         m_edges = 0;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] sel_exp(input logic [3:0] ins);
        case (ins)
            4'h0:    return 4'b0011;
            4'h1:    return 4'b0100;
            4'h2:    return 4'b0010;
            default: return 4'b1000;
        endcase
    endfunction

    function automatic logic dr_out(input logic [3:0] ins);
        case (ins)
            4'h0, 4'h2: return m_bsr[0];
            4'h1:       return m_idc[0];
            default:    return m_byp;
        endcase
    endfunction

    task automatic model_reset();
        m_state = 4'hF; m_ir = 4'h1; m_instr = 4'h1;
        m_shdr = 1'b0; m_upd = 1'b0; m_en = 1'b0; m_tdo = 1'b0; m_tdoen = 1'b0;
    endtask

    task automatic check_all();
        chk("state", 32'(TapState), 32'(m_state));
        chk("instr", 32'(Instruction), 32'(m_instr));
        chk("shiftdr", 32'(ShiftDR), 32'(m_shdr));
        chk("updatedr", 32'(UpdateDR), 32'(m_upd));
        chk("tdo", 32'(TDO), 32'(m_tdo));
        chk("tdoen", 32'(TDOEnable), 32'(m_tdoen));
        chk("selects", 32'({SelectBypass, SelectIdcode, SelectBsr, Mode}), 32'(sel_exp(m_instr)));
        chk("clkdr_edges", 32'(clk_edges), 32'(m_edges));
    endtask

    task automatic rise(input logic tms, input logic tdi);
        TMS = tms;
        TDI = tdi;
        @(posedge TCK);
        if (m_en) begin
            m_edges++;
            m_byp = m_shdr ? tdi : 1'b0;
            m_idc = m_shdr ? {tdi, m_idc[7:1]} : 8'h3C;
            m_bsr = m_shdr ? {tdi, m_bsr[7:1]} : 8'hA5;
        end
        if (m_state == 4'hE)      m_ir = 4'h1;
        else if (m_state == 4'hA) m_ir = {tdi, m_ir[3:1]};
        m_state = tms ? nx1[m_state] : nx0[m_state];
    endtask

    task automatic fall();
        @(negedge TCK);
        m_shdr = (m_state == 4'h2);
        m_upd  = (m_state == 4'h5);
        m_en   = (m_state == 4'h6) || (m_state == 4'h2);
        if (m_state == 4'hA) begin
            m_tdo = m_ir[0]; m_tdoen = 1'b1;
        end else if (m_state == 4'h2) begin
            m_tdo = dr_out(m_instr); m_tdoen = 1'b1;
        end else begin
            m_tdo = 1'b0; m_tdoen = 1'b0;
        end
        if (m_state == 4'hD)      m_instr = m_ir;
        else if (m_state == 4'hF) m_instr = 4'h1;
        #1;
        check_all();
    endtask

    task automatic step(input logic tms, input logic tdi);
        rise(tms, tdi);
        fall();
    endtask

    task automatic rnd_bit(output logic b);
        b = 1'($urandom_range(0, 1));
    endtask

    // From RTI: load an opcode LSB first and return to RTI
    task automatic load_ir(input logic [3:0] op);
        step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(i == 3, op[i]);
        step(1'b1, 1'b0); step(1'b0, 1'b0);
    endtask

    string      paths [16];
    logic [3:0] tdo_a [4];
    logic [3:0] tdo_b;
    logic [3:0] tdo_q;
    logic       rb;
    int         e0, u0;

    initial begin
        paths[4'hF] = "";       paths[4'hC] = "0";       paths[4'h7] = "01";
        paths[4'h6] = "010";    paths[4'h2] = "0100";    paths[4'h1] = "0101";
        paths[4'h3] = "01010";  paths[4'h0] = "010101";  paths[4'h5] = "01011";
        paths[4'h4] = "011";    paths[4'hE] = "0110";    paths[4'hA] = "01100";
        paths[4'h9] = "01101";  paths[4'hB] = "011010";  paths[4'h8] = "0110101";
        paths[4'hD] = "011011";

        r_byp = 1'b0; r_idc = 8'h00; r_bsr = 8'h00;
        m_byp = 1'b0; m_idc = 8'h00; m_bsr = 8'h00;
        TMS = 1'b1; TDI = 1'b0; Reset = 1'b1;
        model_reset();
        @(negedge TCK); @(negedge TCK); #1;
        check_all();
        chk("rst_clockdr", 32'(ClockDR), 32'd0);
        Reset = 1'b0;

        // Go to RTI, load BYPASS through the IR and watch the capture pattern
        step(1'b0, 1'b0);
        step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b1);
        tdo_q[0] = TDO;
        for (int i = 0; i < 4; i++) begin
            step(i == 3, 1'b1);
            if (i < 3) tdo_q[i+1] = TDO;
        end
        chk("ir_capture_tdo", 32'(tdo_q), 32'(4'b0001));
        step(1'b1, 1'b0);
        chk("ir_bypass_instr", 32'(Instruction), 32'hF);
        chk("ir_bypass_sel", 32'(SelectBypass), 32'd1);
        step(1'b0, 1'b0);

        // Bypass DR scan of 1,0,1,1
        e0 = clk_edges; u0 = upd_pulses;
        step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b1);
        tdo_q[0] = TDO;
        step(1'b0, 1'b1); tdo_q[1] = TDO;
        step(1'b0, 1'b0); tdo_q[2] = TDO;
        step(1'b0, 1'b1); tdo_q[3] = TDO;
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        chk("byp_tdo", 32'({tdo_q[3], tdo_q[2], tdo_q[1], tdo_q[0]}), 32'(4'b1010));
        chk("byp_clk_edges", 32'(clk_edges - e0), 32'd5);
        chk("byp_upd_pulses", 32'(upd_pulses - u0), 32'd1);

        // Asynchronous reset in the middle of a DR shift, TCK high
        step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
        rise(1'b0, 1'b1);
        #2;
        Reset = 1'b1;
        #1;
        chk("arst_state", 32'(TapState), 32'hF);
        chk("arst_instr", 32'(Instruction), 32'h1);
        chk("arst_shiftdr", 32'(ShiftDR), 32'd0);
        chk("arst_tdoen", 32'(TDOEnable), 32'd0);
        chk("arst_clockdr", 32'(ClockDR), 32'd0);
        model_reset();
        @(negedge TCK); #1;
        check_all();
        Reset = 1'b0;
        step(1'b0, 1'b0);

        // Undefined opcode and EXTEST decode
        load_ir(4'b0101);
        chk("dec_undef", 32'({SelectBypass, SelectIdcode, SelectBsr, Mode}), 32'(4'b1000));
        load_ir(4'b0000);
        chk("dec_extest", 32'({SelectBypass, SelectIdcode, SelectBsr, Mode}), 32'(4'b0011));

        // BSR shift, uninterrupted then with a pause after two bits
        tdo_b = 4'b1011;
        step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
        tdo_q[0] = TDO;
        for (int i = 0; i < 4; i++) begin
            step(i == 3, tdo_b[i]);
            if (i < 3) tdo_q[i+1] = TDO;
        end
        tdo_a[0] = tdo_q;
        step(1'b1, 1'b0); step(1'b0, 1'b0);
        chk("bsr_plain_tdo", 32'(tdo_a[0]), 32'(4'b0101));

        step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
        tdo_q[0] = TDO;
        step(1'b0, tdo_b[0]); tdo_q[1] = TDO;
        step(1'b1, tdo_b[1]);
        e0 = clk_edges;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1);
            chk("pause_tdoen", 32'(TDOEnable), 32'd0);
        end
        step(1'b1, 1'b0);
        chk("pause_clk_edges", 32'(clk_edges - e0), 32'd0);
        step(1'b0, 1'b0); tdo_q[2] = TDO;
        step(1'b0, tdo_b[2]); tdo_q[3] = TDO;
        step(1'b1, tdo_b[3]);
        step(1'b1, 1'b0); step(1'b0, 1'b0);
        chk("bsr_pause_tdo", 32'(tdo_q), 32'(tdo_a[0]));

        // Reach every state, take one arc, then TMS=1 x5 must land in TLR
        for (int b = 0; b < 2; b++) begin
            for (int s = 0; s < 16; s++) begin
                string p;
                for (int k = 0; k < 5; k++) step(1'b1, 1'b0);
                p = paths[s];
                for (int i = 0; i < p.len(); i++) begin
                    rnd_bit(rb);
                    step(p[i] == 8'd49, rb);
                end
                chk("reach_state", 32'(TapState), 32'(s));
                rnd_bit(rb);
                step(b == 1, rb);
                for (int k = 0; k < 5; k++) step(1'b1, 1'b0);
                chk("tms5_tlr", 32'(TapState), 32'hF);
            end
        end

        // Random walk, with one asynchronous reset part way through
        for (int n = 0; n < 400; n++) begin
            rnd_bit(rb);
            step($urandom_range(0, 99) < 40, rb);
            if (n == 200) begin
                Reset = 1'b1;
                #1;
                model_reset();
                check_all();
                Reset = 1'b0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
